riscv_tcm_mem: RTL and testbench

//  Single-cycle tightly-coupled memory (TCM) serving a RISC-V core: one 64-bit

---
 rtl/riscv_tcm_mem.sv | 142 ++++++++++++++
 tb/tb_riscv_tcm_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_tcm_mem.sv
// ---------------------------------------------------------------------------
// riscv_tcm_mem
//   Single-cycle tightly-coupled memory for a RISC-V core. One shared
//   byte-addressed array, stored as 64-bit words, serves two ports:
//     - a 64-bit instruction fetch port (read only)
//     - a 32-bit tagged data port (load / byte-enabled store / cache ops)
//   Both ports return their result on the cycle after the request. Reads are
//   read-first, so a same-cycle store is visible only to later requests.
//   Address bits above the array size are ignored, so aliases wrap.
//   The contents can be preloaded through the write() backdoor task.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   mem_i_rd_i, mem_i_pc_i         fetch request / fetch address
//   mem_i_flush_i, _invalidate_i   icache hints (no effect)
//   mem_i_accept_o/valid_o/error_o fetch handshake (accept=1, error=0)
//   mem_i_inst_o                   fetched 64-bit word
//   mem_d_addr_i, mem_d_data_wr_i  data address / store data
//   mem_d_rd_i, mem_d_wr_i         load request / store byte enables
//   mem_d_cacheable_i              ignored attribute
//   mem_d_req_tag_i                request tag, echoed on mem_d_resp_tag_o
//   mem_d_invalidate_i/_writeback_i/_flush_i  cache ops (ack only)
//   mem_d_data_rd_o                load data
//   mem_d_accept_o/ack_o/error_o   data handshake (accept=1, error=0)
// ---------------------------------------------------------------------------
module riscv_tcm_mem #(
    parameter int MEM_BYTES = 131072
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 8;

    logic [63:0] ram [0:WORDS-1];

    logic [AW-4:0] i_idx;
    logic [AW-4:0] d_idx;
    logic          d_req;
    logic [7:0]    lane_we;
    logic [63:0]   lane_wdata;

    logic          valid_reg;
    logic          ack_reg;
    logic [63:0]   inst_reg;
    logic [31:0]   data_rd_reg;
    logic [10:0]   tag_reg;

    assign i_idx = mem_i_pc_i[AW-1:3];
    assign d_idx = mem_d_addr_i[AW-1:3];
    assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                 | mem_d_writeback_i | mem_d_flush_i;

    // Map the 4 store lanes onto the 64-bit word half picked by addr[2].
    // Stores presented while in reset are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam bit HALF = (gi >= 4);
            assign lane_we[gi]            = ~rst_i & (mem_d_addr_i[2] == HALF)
                                          & mem_d_wr_i[gi % 4];
            assign lane_wdata[gi*8 +: 8]  = mem_d_data_wr_i[(gi % 4)*8 +: 8];
        end
    endgenerate

    // Array process: plain always because the backdoor task also writes the
    // array. Registered reads sample the array before this edge's writes.
    always @(posedge clk_i) begin
        for (int i = 0; i < 8; i++) begin
            if (lane_we[i])
                ram[d_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
        end
        if (rst_i) begin
            inst_reg    <= 64'd0;
            data_rd_reg <= 32'd0;
        end else begin
            if (mem_i_rd_i)
                inst_reg <= ram[i_idx];
            if (d_req)
                data_rd_reg <= mem_d_addr_i[2] ? ram[d_idx][63:32] : ram[d_idx][31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
            tag_reg   <= 11'd0;
        end else begin
            valid_reg <= mem_i_rd_i;
            ack_reg   <= d_req;
            if (d_req)
                tag_reg <= mem_d_req_tag_i;
        end
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_error_o    = 1'b0;
    assign mem_i_valid_o    = valid_reg;
    assign mem_i_inst_o     = inst_reg;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_ack_o      = ack_reg;
    assign mem_d_data_rd_o  = data_rd_reg;
    assign mem_d_resp_tag_o = tag_reg;

    // Inputs that carry no function in a TCM.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, mem_i_flush_i, mem_i_invalidate_i,
                             mem_d_cacheable_i, mem_i_pc_i[2:0],
                             mem_d_addr_i[1:0], mem_i_pc_i[31:AW],
                             mem_d_addr_i[31:AW]};

    // Backdoor preload: updates one byte, addressed modulo the array size.
    task write(input logic [31:0] addr, input logic [7:0] data);
        ram[addr[AW-1:3]][{addr[2:0], 3'b000} +: 8] <= data;
    endtask

endmodule

// File: tb/tb_riscv_tcm_mem.sv
// ---------------------------------------------------------------------------
// tb_riscv_tcm_mem
//   Directed bench for riscv_tcm_mem: reset behaviour, fetch, byte-enabled
//   store, read-first collision, fetch/store collision, upper-half store,
//   address wrap, cache-op ack and array retention across reset.
// ---------------------------------------------------------------------------
module tb_riscv_tcm_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    riscv_tcm_mem dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mem_i_rd_i         (mem_i_rd_i),
        .mem_i_flush_i      (mem_i_flush_i),
        .mem_i_invalidate_i (mem_i_invalidate_i),
        .mem_i_pc_i         (mem_i_pc_i),
        .mem_i_accept_o     (mem_i_accept_o),
        .mem_i_valid_o      (mem_i_valid_o),
        .mem_i_error_o      (mem_i_error_o),
        .mem_i_inst_o       (mem_i_inst_o),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_cacheable_i  (mem_d_cacheable_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_flush_i      (mem_d_flush_i),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_i_rd_i         = 1'b0;
        mem_i_flush_i      = 1'b0;
        mem_i_invalidate_i = 1'b0;
        mem_i_pc_i         = 32'h0;
        mem_d_addr_i       = 32'h0;
        mem_d_data_wr_i    = 32'h0;
        mem_d_rd_i         = 1'b0;
        mem_d_wr_i         = 4'h0;
        mem_d_cacheable_i  = 1'b1;
        mem_d_req_tag_i    = 11'h0;
        mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i  = 1'b0;
        mem_d_flush_i      = 1'b0;
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic data_req(input logic [31:0] addr, input logic rd, input logic [3:0] wr,
                            input logic [31:0] wdata, input logic [10:0] tag);
        idle_inputs();
        mem_d_addr_i    = addr;
        mem_d_rd_i      = rd;
        mem_d_wr_i      = wr;
        mem_d_data_wr_i = wdata;
        mem_d_req_tag_i = tag;
    endtask

    initial begin
        idle_inputs();
        rst_i      = 1'b1;
        mem_i_rd_i = 1'b1;
        mem_d_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0000;
        mem_d_req_tag_i = 11'h3FF;

        // Reset held 5 cycles with requests asserted: nothing comes back.
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("rst_valid_c%0d", c), {63'd0, mem_i_valid_o}, 64'd0);
            chk($sformatf("rst_ack_c%0d", c),   {63'd0, mem_d_ack_o},   64'd0);
        end
        chk("rst_inst", mem_i_inst_o, 64'd0);
        chk("rst_data", {32'd0, mem_d_data_rd_o}, 64'd0);
        chk("rst_tag",  {53'd0, mem_d_resp_tag_o}, 64'd0);
        chk("accept_error", {60'd0, mem_i_accept_o, mem_d_accept_o, mem_i_error_o, mem_d_error_o}, 64'hC);

        // Backdoor preload: program bytes at 0..7, zeros where stores land.
        dut.write(32'h0, 8'h13); dut.write(32'h1, 8'h00);
        dut.write(32'h2, 8'h00); dut.write(32'h3, 8'h00);
        dut.write(32'h4, 8'h93); dut.write(32'h5, 8'h00);
        dut.write(32'h6, 8'h10); dut.write(32'h7, 8'h00);
        for (int b = 0; b < 8; b++) begin
            dut.write(32'h100 + b, 8'h00);
            dut.write(32'h008 + b, 8'h00);
        end
        idle_inputs();
        rst_i = 1'b0;
        step();

        // Fetch with pc[2:0] != 0 still returns the whole aligned word.
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0004;
        step();
        chk("fetch_valid", {63'd0, mem_i_valid_o}, 64'd1);
        chk("fetch_inst",  mem_i_inst_o, 64'h00100093_00000013);
        mem_i_rd_i = 1'b0;
        step();
        chk("fetch_idle_valid", {63'd0, mem_i_valid_o}, 64'd0);

        // Byte-enabled store lanes 0 and 2.
        data_req(32'h8000_0100, 1'b0, 4'b0101, 32'hDEADBEEF, 11'h07F);
        step();
        chk("store_ack",  {63'd0, mem_d_ack_o}, 64'd1);
        chk("store_tag",  {53'd0, mem_d_resp_tag_o}, 64'h07F);
        chk("store_data_old", {32'd0, mem_d_data_rd_o}, 64'h0);
        data_req(32'h8000_0100, 1'b1, 4'h0, 32'h0, 11'h012);
        step();
        chk("load_after_store", {32'd0, mem_d_data_rd_o}, 64'h00AD00EF);
        chk("load_tag", {53'd0, mem_d_resp_tag_o}, 64'h012);

        // Load+store and fetch of the same word in one cycle: old data out.
        data_req(32'h8000_0100, 1'b1, 4'hF, 32'h11223344, 11'h001);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0100;
        step();
        chk("readfirst_data", {32'd0, mem_d_data_rd_o}, 64'h00AD00EF);
        chk("readfirst_fetch", mem_i_inst_o, 64'h00000000_00AD00EF);
        data_req(32'h8000_0100, 1'b1, 4'h0, 32'h0, 11'h002);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8000_0100;
        step();
        chk("readfirst_next", {32'd0, mem_d_data_rd_o}, 64'h11223344);
        chk("fetch_after_store", mem_i_inst_o, 64'h00000000_11223344);

        // Store into the upper half of the 64-bit word.
        data_req(32'h8000_0104, 1'b0, 4'hF, 32'hA5A5A5A5, 11'h003);
        step();
        data_req(32'h8000_0104, 1'b1, 4'h0, 32'h0, 11'h004);
        step();
        chk("upper_half", {32'd0, mem_d_data_rd_o}, 64'hA5A5A5A5);
        data_req(32'h8000_0100, 1'b1, 4'h0, 32'h0, 11'h005);
        step();
        chk("lower_half_kept", {32'd0, mem_d_data_rd_o}, 64'h11223344);

        // Address wrap modulo array size.
        data_req(32'h8002_0008, 1'b0, 4'hF, 32'hCAFEF00D, 11'h006);
        step();
        data_req(32'h8000_0008, 1'b1, 4'h0, 32'h0, 11'h007);
        step();
        chk("wrap_load", {32'd0, mem_d_data_rd_o}, 64'hCAFEF00D);

        // Flush op: ack with tag, returns the word, no array change.
        data_req(32'h8000_0100, 1'b0, 4'h0, 32'hFFFFFFFF, 11'h5A1);
        mem_d_flush_i = 1'b1;
        step();
        chk("flush_ack", {63'd0, mem_d_ack_o}, 64'd1);
        chk("flush_tag", {53'd0, mem_d_resp_tag_o}, 64'h5A1);
        chk("flush_data", {32'd0, mem_d_data_rd_o}, 64'h11223344);
        idle_inputs();
        step();
        chk("idle_ack", {63'd0, mem_d_ack_o}, 64'd0);
        data_req(32'h8000_0100, 1'b1, 4'h0, 32'h0, 11'h008);
        step();
        chk("flush_mem_unchanged", {32'd0, mem_d_data_rd_o}, 64'h11223344);

        // Reset with a store presented: outputs clear, store dropped,
        // array contents survive.
        data_req(32'h8000_0100, 1'b1, 4'hF, 32'h99999999, 11'h009);
        mem_i_rd_i = 1'b1;
        rst_i = 1'b1;
        step();
        chk("rst2_ack",  {63'd0, mem_d_ack_o}, 64'd0);
        chk("rst2_valid", {63'd0, mem_i_valid_o}, 64'd0);
        chk("rst2_data", {32'd0, mem_d_data_rd_o}, 64'd0);
        chk("rst2_tag",  {53'd0, mem_d_resp_tag_o}, 64'd0);
        rst_i = 1'b0;
        data_req(32'h8000_0100, 1'b1, 4'h0, 32'h0, 11'h00A);
        step();
        chk("retained_after_rst", {32'd0, mem_d_data_rd_o}, 64'h11223344);
        chk("retained_ack", {63'd0, mem_d_ack_o}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
